// File: rtl/gray_bin_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gray_bin_pipe
// Function : Two-stage valid/ready pipeline that converts each word either
//            Gray-to-binary (in_mode=0) or binary-to-Gray (in_mode=1).
//            Optional Gray adjacency checker enabled by the compile-time
//            macro GRAY_BIN_ADJ_CHK_EN (flags mode-0 words whose Hamming
//            distance from the previous mode-0 word exceeds 1).
// Revision : 1.0 - initial release
// ============================================================================
module gray_bin_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    logic             s1_valid_q;
    logic             s1_mode_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic [WIDTH-1:0] s2_data_d;

    // ------------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its content moves on.
    // ------------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_xfer;
    logic w_s2_load;

    assign w_s2_adv  = ~s2_valid_q | out_ready;
    assign w_s1_adv  = ~s1_valid_q | w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_in_xfer = in_valid & w_s1_adv;
    assign w_s2_load = w_s2_adv & s1_valid_q;

    // ------------------------------------------------------------------------
    // Conversion logic operating on the S1 word
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_b2g;

    // Each binary bit is the XOR of all Gray bits at or above its position.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign w_g2b[gi] = ^s1_data_q[WIDTH-1:gi];
        end
    endgenerate

    assign w_b2g = s1_data_q ^ (s1_data_q >> 1);

    // Select the converted value per word according to its captured mode.
    always_comb begin
        s2_data_d = s2_data_q;
        if (w_s2_load) begin
            s2_data_d = s1_mode_q ? w_b2g : w_g2b;
        end
    end

    // S1 captures the incoming word and its mode on every input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
        end else if (w_s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mode_q <= in_mode;
                s1_data_q <= in_data;
            end
        end
    end

    // S2 holds the converted result; it only changes when allowed to advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_data_q <= s2_data_d;
            if (w_s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

`ifdef GRAY_BIN_ADJ_CHK_EN
    // ------------------------------------------------------------------------
    // Adjacency checker: evaluated at input transfer against the last
    // accepted mode-0 word; the flag then travels with its word.
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       CNT_MAX = 8'hFF;

    logic [WIDTH-1:0] hist_q;
    logic             hist_seen_q;
    logic             s1_err_q;
    logic             s2_err_q;
    logic [7:0]       err_cnt_q;
    logic [7:0]       err_cnt_d;
    logic [WIDTH-1:0] w_diff;
    logic             w_multi_bit;
    logic             w_viol;

    // More than one differing bit <=> clearing the lowest set bit leaves some.
    assign w_diff      = in_data ^ hist_q;
    assign w_multi_bit = |(w_diff & (w_diff - ONE_W));
    assign w_viol      = ~in_mode & hist_seen_q & w_multi_bit;

    // Saturating increment when a flagged word lands in S2.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_s2_load && s1_err_q && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // History tracks only accepted mode-0 words; mode-1 words leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            hist_seen_q <= 1'b0;
        end else if (w_in_xfer && !in_mode) begin
            hist_q      <= in_data;
            hist_seen_q <= 1'b1;
        end
    end

    // Error flag pipeline alongside the data stages, plus the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err_q  <= 1'b0;
            s2_err_q  <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (w_in_xfer) begin
                s1_err_q <= w_viol;
            end
            if (w_s2_load) begin
                s2_err_q <= s1_err_q;
            end
        end
    end

    assign out_err = s2_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign out_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_bin_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_bin_pipe
// Function : Directed self-checking bench for gray_bin_pipe (WIDTH=4 and
//            WIDTH=8 instances). Honours GRAY_BIN_ADJ_CHK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_bin_pipe;

`ifdef GRAY_BIN_ADJ_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance signals
    logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_err;
    logic [3:0] a_in_data, a_out_data;
    logic [7:0] a_err_cnt;
    // WIDTH=8 instance signals
    logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_err;
    logic [7:0] b_in_data, b_out_data;
    logic [7:0] b_err_cnt;

    gray_bin_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err(a_out_err), .err_cnt(a_err_cnt)
    );

    gray_bin_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err(b_out_err), .err_cnt(b_err_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Directed stream tables for the WIDTH=4 instance
    logic       s_mode [16];
    logic [3:0] s_data [16];
    logic [3:0] e_data [16];
    logic       e_err  [16];
    logic [7:0] e_cnt  [16];
    logic [7:0] gq     [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int k, input logic m, input logic [3:0] d,
                         input logic [3:0] xd, input logic xe, input logic [7:0] xc);
        s_mode[k] = m;
        s_data[k] = d;
        e_data[k] = xd;
        e_err[k]  = xe & CHK;
        e_cnt[k]  = CHK ? xc : 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Back-to-back stream with out_ready=1; word k must appear two cycles later.
    task automatic run_stream4(input string name, input int len);
        a_out_ready = 1'b1;
        for (int n = 0; n < len + 2; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk({name, "_valid"}, a_out_valid, 1);
                chk($sformatf("%s_data[%0d]", name, n - 2), a_out_data, e_data[n-2]);
                chk($sformatf("%s_err[%0d]", name, n - 2), a_out_err, e_err[n-2]);
                chk($sformatf("%s_cnt[%0d]", name, n - 2), a_err_cnt, e_cnt[n-2]);
            end else begin
                chk({name, "_lat_valid"}, a_out_valid, 0);
            end
            chk({name, "_in_ready"}, a_in_ready, 1);
            if (n < len) begin
                a_in_valid = 1'b1;
                a_in_mode  = s_mode[n];
                a_in_data  = s_data[n];
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk({name, "_drained"}, a_out_valid, 0);
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = 4'h0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = 8'h0; b_out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_err", a_out_err, 0);
        chk("rst_err_cnt", a_err_cnt, 0);
        rst_n = 1'b1;

        // ---------------- Gray-to-binary stream ----------------
        set_w(0, 0, 4'b0001, 4'b0001, 0, 0);
        set_w(1, 0, 4'b0010, 4'b0011, 1, 1);
        set_w(2, 0, 4'b0111, 4'b0101, 1, 2);
        set_w(3, 0, 4'b0101, 4'b0110, 0, 2);
        set_w(4, 0, 4'b0100, 4'b0111, 0, 2);
        set_w(5, 0, 4'b1101, 4'b1001, 1, 3);
        set_w(6, 0, 4'b1111, 4'b1010, 0, 3);
        set_w(7, 0, 4'b1110, 4'b1011, 0, 3);
        set_w(8, 0, 4'b1011, 4'b1101, 1, 4);
        run_stream4("g2b", 9);

        // ---------------- binary-to-Gray and alternating modes ----------------
        do_reset();
        set_w(0, 1, 4'b0101, 4'b0111, 0, 0);
        set_w(1, 1, 4'b1001, 4'b1101, 0, 0);
        set_w(2, 1, 4'b0011, 4'b0010, 0, 0);
        set_w(3, 0, 4'b0011, 4'b0010, 0, 0);
        set_w(4, 1, 4'b1010, 4'b1111, 0, 0);
        set_w(5, 0, 4'b1010, 4'b1100, 1, 1);
        set_w(6, 1, 4'b1111, 4'b1000, 0, 1);
        set_w(7, 0, 4'b1111, 4'b1010, 1, 2);
        run_stream4("mix", 8);

        // ---------------- backpressure ----------------
        do_reset();
        @(negedge clk);
        a_out_ready = 1'b0; a_in_mode = 1'b1; a_in_valid = 1'b1; a_in_data = 4'h1;
        @(negedge clk);
        chk("bp_ready_after1", a_in_ready, 1);
        chk("bp_valid_after1", a_out_valid, 0);
        a_in_data = 4'h2;
        @(negedge clk);
        chk("bp_ready_drop", a_in_ready, 0);
        chk("bp_hold_valid0", a_out_valid, 1);
        chk("bp_hold_data0", a_out_data, 4'h1);
        a_in_data = 4'hF;
        @(negedge clk);
        chk("bp_ready_low1", a_in_ready, 0);
        chk("bp_hold_valid1", a_out_valid, 1);
        chk("bp_hold_data1", a_out_data, 4'h1);
        a_in_data = 4'h9;
        @(negedge clk);
        chk("bp_ready_low2", a_in_ready, 0);
        chk("bp_hold_data2", a_out_data, 4'h1);
        a_in_data = 4'hE;
        @(negedge clk);
        chk("bp_ready_low3", a_in_ready, 0);
        chk("bp_hold_valid3", a_out_valid, 1);
        chk("bp_hold_data3", a_out_data, 4'h1);
        a_out_ready = 1'b1; a_in_data = 4'h3;
        #1;
        chk("bp_ready_release", a_in_ready, 1);
        @(negedge clk);
        chk("bp_out_w1", a_out_data, 4'h3);
        a_in_data = 4'h4;
        @(negedge clk);
        chk("bp_out_w2", a_out_data, 4'h2);
        a_in_data = 4'h5;
        @(negedge clk);
        chk("bp_out_w3", a_out_data, 4'h6);
        a_in_data = 4'h6;
        @(negedge clk);
        chk("bp_out_w4", a_out_data, 4'h7);
        chk("bp_out_w4_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out_w5", a_out_data, 4'h5);
        @(negedge clk);
        chk("bp_drained", a_out_valid, 0);

        // ---------------- adjacency checker sequence ----------------
        do_reset();
        set_w(0, 0, 4'b0001, 4'b0001, 0, 0);
        set_w(1, 0, 4'b0010, 4'b0011, 1, 1);
        set_w(2, 0, 4'b0011, 4'b0010, 0, 1);
        run_stream4("adj", 3);

        // ---------------- reset with both stages full ----------------
        a_out_ready = 1'b0; a_in_mode = 1'b0; a_in_valid = 1'b1; a_in_data = 4'b0001;
        @(negedge clk);
        a_in_data = 4'b0010;
        @(negedge clk);
        chk("rr_full_valid", a_out_valid, 1);
        chk("rr_full_ready", a_in_ready, 0);
        chk("rr_pre_cnt", a_err_cnt, CHK ? 8'd1 : 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_async_valid", a_out_valid, 0);
        chk("rr_async_ready", a_in_ready, 1);
        chk("rr_async_cnt", a_err_cnt, 0);
        chk("rr_async_data", a_out_data, 0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rr_no_stale", a_out_valid, 0);
        end
        a_in_valid = 1'b1; a_in_data = 4'b0110;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("rr_post_valid", a_out_valid, 1);
        chk("rr_post_data", a_out_data, 4'b0100);
        chk("rr_post_err", a_out_err, 0);
        @(negedge clk);
        chk("rr_post_drained", a_out_valid, 0);

        // ---------------- WIDTH=8 round trip ----------------
        do_reset();
        b_in_mode = 1'b1;
        for (int n = 0; n < 258; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk("rt_b2g_valid", b_out_valid, 1);
                gq[n-2] = b_out_data;
            end
            if (n < 256) begin
                b_in_valid = 1'b1;
                b_in_data  = n[7:0];
            end else begin
                b_in_valid = 1'b0;
            end
        end
        chk("rt_g_05", gq[5], 8'h07);
        chk("rt_g_80", gq[128], 8'hC0);
        chk("rt_g_ff", gq[255], 8'h80);
        b_in_mode = 1'b0;
        for (int n = 0; n < 258; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk("rt_g2b_valid", b_out_valid, 1);
                chk($sformatf("rt_identity[%0d]", n - 2), b_out_data, n - 2);
            end
            if (n < 256) begin
                b_in_valid = 1'b1;
                b_in_data  = gq[n];
            end else begin
                b_in_valid = 1'b0;
            end
        end

        // ---------------- error counter saturation ----------------
        do_reset();
        b_in_mode = 1'b0;
        for (int n = 0; n < 304; n++) begin
            @(negedge clk);
            if (n == 256) chk("sat_cnt_254", b_err_cnt, CHK ? 8'd254 : 8'd0);
            if (n == 302) chk("sat_last_err", b_out_err, CHK);
            if (n < 301) begin
                b_in_valid = 1'b1;
                b_in_data  = n[0] ? 8'hFF : 8'h00;
            end else begin
                b_in_valid = 1'b0;
            end
        end
        chk("sat_cnt_final", b_err_cnt, CHK ? 8'd255 : 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_bin_pipe.md
GRAY_BIN_PIPE -- requirements
Module: gray_bin_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream word present.
REQ-005 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-006 SHALL have port: in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray; sampled together with in_data.
REQ-007 SHALL have port: in_data  input  WIDTH  word to convert.
REQ-008 SHALL have port: out_valid  output  1  converted word present.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the word this cycle.
REQ-010 SHALL have port: out_data  output  WIDTH  converted word.
REQ-011 SHALL have port: out_err  output  1  adjacency-violation flag travelling with out_data.
REQ-012 SHALL have port: err_cnt  output  8  saturating count of adjacency violations.

Function
REQ-013 SHALL transfer an input on a cycle where in_valid and in_ready are both 1; SHALL transfer an output on a cycle where out_valid and out_ready are both 1.
REQ-014 SHALL use two register stages: S1 captures in_data/in_mode; S2 captures the converted result and out_err.
REQ-015 SHALL have a latency of 2 cycles from input transfer to out_valid=1 when there is no stall, and SHALL sustain one word per cycle.
REQ-016 SHALL compute Gray-to-binary as b[WIDTH-1]=g[WIDTH-1], b[i]=b[i+1] XOR g[i]; binary-to-Gray as g = b XOR (b >> 1).
REQ-017 SHALL advance S2 when S2 is empty or out_ready=1; SHALL advance S1 when S1 is empty or S2 advances; in_ready SHALL equal the S1 advance condition, combinationally from out_ready.
REQ-018 SHALL hold out_data, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL never drop or duplicate a word; with both stages full and out_ready=0, in_ready SHALL be 0.
REQ-020 SHALL keep word order; a mode change between consecutive words SHALL take effect per word with no bubble.
REQ-021 SHALL keep out_data, out_err and out_valid unaffected by in_valid/in_data when in_ready=0.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear both stage valids, out_data, out_err, err_cnt and the adjacency history register to 0.
REQ-023 SHALL discard any in-flight words on reset mid-operation; out_valid SHALL be 0 on the first rising clk edge after rst_n is released.
REQ-024 SHALL leave in_ready at 1 while out of reset with the pipeline empty.

Configuration
REQ-025 SHALL have a compile-time option controlled by macro GRAY_BIN_ADJ_CHK_EN.
REQ-026 SHALL, with GRAY_BIN_ADJ_CHK_EN defined, compare each accepted mode-0 word against the previous accepted mode-0 word. It SHALL set out_err=1 on that word's output when the Hamming distance exceeds 1, and SHALL increment err_cnt, saturating at 255.
REQ-027 SHALL, with GRAY_BIN_ADJ_CHK_EN defined, not check the first mode-0 word after reset and SHALL not check mode-1 words; mode-1 words SHALL leave the history register unchanged.
REQ-028 SHALL, without GRAY_BIN_ADJ_CHK_EN, tie out_err and err_cnt to 0, omit the checker logic, and leave all other behaviour identical.

Verification
REQ-029 SHALL be verified, at WIDTH=4 with mode 0 and out_ready=1, by this stream: 0001, 0010, 0111, 0101, 0100, 1101, 1111, 1110, 1011. The bench SHALL check outputs 0001, 0011, 0101, 0110, 0111, 1001, 1010, 1011, 1101 at 2-cycle latency, one per cycle.
REQ-030 SHALL be verified by a mode-1 test: input 0101 -> 0111; input 1001 -> 1101; then an alternating-mode back-to-back stream with per-word results correct and no bubbles.
REQ-031 SHALL be verified by a backpressure test: hold out_ready=0 for 5 cycles during streaming, then check in_ready drops after 2 accepted words, out_data is held, and all words arrive in order after release.
REQ-032 SHALL be verified by a reset test: assert rst_n low while both stages are full, then check out_valid=0, err_cnt=0, in_ready=1, and no stale word emitted after release.
REQ-033 SHALL be verified, with GRAY_BIN_ADJ_CHK_EN defined, by sequence 0001 then 0010: the second output has out_err=1 and err_cnt=1; a following 0011 has out_err=0.
REQ-034 SHALL be verified by WIDTH=8 with an exhaustive sweep of all 256 values, round-tripped mode 1 then mode 0, checking identity; and, with GRAY_BIN_ADJ_CHK_EN defined, by 300 violations checking that err_cnt saturates at 255.
